sync_fifo_flex: RTL and testbench
=================================

SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16: number of storage words; power of two, 4 to 4096.
REQ-002 SHALL have parameter FIFO_WIDTH, default 32: data word width in bits, 1 to 1024.
REQ-003 SHALL have parameter FWFT_MODE, default 0: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 SHALL have port fifo_clk, input, 1 bit: single clock for all logic.
REQ-005 SHALL have port fifo_sync_rst, input, 1 bit: reset, synchronous to fifo_clk, active-high.
REQ-006 SHALL have port fifo_flush, input, 1 bit: synchronous clear of contents and status.
REQ-007 SHALL have port fifo_write, input, 1 bit: write request.
REQ-008 SHALL have port fifo_input, input, FIFO_WIDTH bits: write data.
REQ-009 SHALL have port fifo_read, input, 1 bit: read request.
REQ-010 SHALL have port prog_full_thresh, input, PTR_WIDTH+1 bits: programmable-full level, where PTR_WIDTH = log2(FIFO_DEPTH).
REQ-011 SHALL have port prog_empty_thresh, input, PTR_WIDTH+1 bits: programmable-empty level.
REQ-012 SHALL have port fifo_output, output, FIFO_WIDTH bits: read data.
REQ-013 SHALL have port fifo_valid, output, 1 bit: fifo_output holds a valid word.
REQ-014 SHALL have ports fifo_full and fifo_empty, output, 1 bit each.
REQ-015 SHALL have ports prog_full and prog_empty, output, 1 bit each.
REQ-016 SHALL have port fifo_count, output, PTR_WIDTH+1 bits: words currently stored.
REQ-017 SHALL have ports fifo_overflow and fifo_underflow, output, 1 bit each: sticky error flags.

Function
REQ-018 Pointers SHALL be PTR_WIDTH+1 bits wide, and fifo_count SHALL equal wr_ptr minus rd_ptr, modulo 2^(PTR_WIDTH+1).
REQ-019 fifo_full SHALL equal (fifo_count == FIFO_DEPTH), and fifo_empty SHALL equal (fifo_count == 0).
REQ-020 prog_full SHALL equal (fifo_count >= prog_full_thresh), and prog_empty SHALL equal (fifo_count <= prog_empty_thresh); both are combinational and use unsigned compares.
REQ-021 A write SHALL be accepted iff fifo_write && !fifo_full && !fifo_flush; the word is stored at wr_ptr and wr_ptr increments.
REQ-022 A read SHALL be accepted iff fifo_read && !fifo_empty && !fifo_flush, and rd_ptr SHALL increment.
REQ-023 Full and empty SHALL be evaluated on the pre-edge count: a write at full is rejected even if a read is accepted in the same cycle, and a read at empty is rejected even if a write is accepted in the same cycle.
REQ-024 With simultaneous accepted read and write, fifo_count SHALL be unchanged.
REQ-025 FWFT_MODE=0: on an accepted read, fifo_output SHALL load mem[rd_ptr] at the next edge, and fifo_valid SHALL be 1 for exactly that following cycle; otherwise fifo_output SHALL hold its value and fifo_valid SHALL be 0.
REQ-026 FWFT_MODE=1: fifo_output SHALL present mem[rd_ptr] combinationally, fifo_valid SHALL equal !fifo_empty, and an accepted read SHALL advance to the next word at the next edge.
REQ-027 fifo_overflow SHALL set at the edge after fifo_write && fifo_full, and fifo_underflow SHALL set at the edge after fifo_read && fifo_empty.
REQ-028 Both error flags SHALL hold until reset or flush.
REQ-029 fifo_flush SHALL take priority over read and write, and at the next edge SHALL clear the pointers, fifo_valid and both error flags.
REQ-030 fifo_flush SHALL leave memory contents and fifo_output unchanged.
REQ-031 Pointer wrap-around SHALL be seamless: FIFO_DEPTH writes after FIFO_DEPTH reads SHALL produce no false full or empty indication.

Reset
REQ-032 While fifo_sync_rst=1 at an edge, the block SHALL load wr_ptr=0, rd_ptr=0, fifo_output=0, fifo_valid=0, fifo_overflow=0 and fifo_underflow=0; as a result fifo_empty=1, fifo_full=0 and fifo_count=0.
REQ-033 Reset SHALL have priority over flush, read and write, and a reset mid-operation SHALL discard all stored words.
REQ-034 Memory SHALL NOT be reset.

Structure
REQ-035 Package sync_fifo_pkg SHALL hold the PTR_WIDTH derivation function and the FWFT_STD and FWFT_ON mode constants.
REQ-036 Storage SHALL be sub-module sync_fifo_ram (one write port, one read port; combinational read for FWFT, registered read otherwise); pointer, flag and count logic SHALL reside in sync_fifo_flex.

Verification
REQ-037 DEPTH=8, FWFT=0: write 8 words 0x01..0x08 -> fifo_full=1 and fifo_count=8; 9th write -> fifo_overflow=1 and count stays 8.
REQ-038 DEPTH=8, FWFT=0: read 8 words -> fifo_output sequence 0x01..0x08, each word one cycle after its read with fifo_valid=1; 9th read -> fifo_underflow=1.
REQ-039 DEPTH=8, FWFT=1: write 0xAA into an empty FIFO -> at the next cycle fifo_valid=1 and fifo_output=0xAA with no read issued.
REQ-040 Count 4, simultaneous read and write for 20 cycles -> fifo_count stays 4 throughout, data order is preserved across pointer wrap, and no flag toggles.
REQ-041 Thresholds full=6 and empty=2: fill from 0 to 8 -> prog_empty=1 for counts 0..2 and prog_full=1 for counts 6..8.
REQ-042 Count 5 with both error flags set: assert fifo_flush together with read and write -> next cycle count=0, fifo_empty=1, flags=0 and no word is written; repeat with fifo_sync_rst -> same state plus fifo_output=0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the sync_fifo_flex slice:
//   FWFT_STD / FWFT_ON : read-mode selector values for FWFT_MODE
//   ptr_width_f()      : address width derived from the storage depth
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  localparam int FWFT_STD = 0;
  localparam int FWFT_ON  = 1;

  // Address width for a power-of-two depth; the pointers carry one extra
  // bit on top of this so that full and empty can be told apart.
  function automatic int ptr_width_f(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// -----------------------------------------------------------------------------
// sync_fifo_ram
// Single-write-port / single-read-port storage for sync_fifo_flex.
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset (read register only, not memory)
//   wr_en    : write strobe, wr_addr / wr_data
//   rd_en    : read strobe (loads the read register in standard mode)
//   rd_addr  : read address
//   rd_data  : combinational mem[rd_addr] when FWFT == FWFT_ON,
//              otherwise the registered read word
// -----------------------------------------------------------------------------
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4,
  parameter int FWFT   = FWFT_STD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rd_q_r;

  // Storage array write; contents deliberately survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Registered read word: loads only on an accepted read, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q_r <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_q_r <= mem_r[rd_addr];
    end
  end

  // Read-data source selection by mode.
  always_comb begin
    rd_data = rd_q_r;
    if (FWFT == FWFT_ON) begin
      rd_data = mem_r[rd_addr];
    end else begin
      rd_data = rd_q_r;
    end
  end

endmodule

// File: rtl/sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex
// Single-clock FIFO with selectable standard / first-word-fall-through read,
// programmable thresholds and sticky overflow / underflow flags.
// Ports:
//   fifo_clk, fifo_sync_rst (sync, active-high), fifo_flush (sync clear)
//   fifo_write / fifo_input      : write request and data
//   fifo_read                    : read request
//   prog_full_thresh / prog_empty_thresh : threshold levels
//   fifo_output / fifo_valid     : read data and its qualifier
//   fifo_full / fifo_empty / prog_full / prog_empty / fifo_count : status
//   fifo_overflow / fifo_underflow : sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_WIDTH = 32,
  parameter int FWFT_MODE  = FWFT_STD,
  localparam int PTR_WIDTH = ptr_width_f(FIFO_DEPTH)
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_sync_rst,
  input  logic                  fifo_flush,
  input  logic                  fifo_write,
  input  logic [FIFO_WIDTH-1:0] fifo_input,
  input  logic                  fifo_read,
  input  logic [PTR_WIDTH:0]    prog_full_thresh,
  input  logic [PTR_WIDTH:0]    prog_empty_thresh,
  output logic [FIFO_WIDTH-1:0] fifo_output,
  output logic                  fifo_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic [PTR_WIDTH:0]    fifo_count,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0] PTR_ONE = (PTR_WIDTH+1)'(32'd1);
  localparam logic [PTR_WIDTH:0] PTR_ZERO = (PTR_WIDTH+1)'(32'd0);

  logic [PTR_WIDTH:0] wr_ptr_r;
  logic [PTR_WIDTH:0] rd_ptr_r;
  logic [PTR_WIDTH:0] count_s;
  logic               full_s;
  logic               empty_s;
  logic               wr_acc_s;
  logic               rd_acc_s;
  logic               valid_r;
  logic               overflow_r;
  logic               underflow_r;
  logic [FIFO_WIDTH-1:0] ram_rd_data_s;

  // Occupancy and status from the pre-edge pointers; the extra pointer bit
  // makes the modulo difference reach FIFO_DEPTH without aliasing to zero.
  always_comb begin
    count_s  = wr_ptr_r - rd_ptr_r;
    full_s   = (count_s == DEPTH_C);
    empty_s  = (count_s == PTR_ZERO);
    wr_acc_s = fifo_write && !full_s  && !fifo_flush;
    rd_acc_s = fifo_read  && !empty_s && !fifo_flush;
  end

  // Pointer update: reset over flush over normal traffic.
  always_ff @(posedge fifo_clk) begin
    if (fifo_sync_rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else if (fifo_flush) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Standard-mode valid: one-cycle pulse following each accepted read.
  always_ff @(posedge fifo_clk) begin
    if (fifo_sync_rst) begin
      valid_r <= 1'b0;
    end else if (fifo_flush) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= rd_acc_s;
    end
  end

  // Sticky error flags; a request against the pre-edge full/empty state sets them.
  always_ff @(posedge fifo_clk) begin
    if (fifo_sync_rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (fifo_flush) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (fifo_write && full_s) begin
        overflow_r <= 1'b1;
      end
      if (fifo_read && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  sync_fifo_ram #(
    .DEPTH  (FIFO_DEPTH),
    .WIDTH  (FIFO_WIDTH),
    .ADDR_W (PTR_WIDTH),
    .FWFT   (FWFT_MODE)
  ) u_ram (
    .clk     (fifo_clk),
    .rst     (fifo_sync_rst),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r[PTR_WIDTH-1:0]),
    .wr_data (fifo_input),
    .rd_en   (rd_acc_s),
    .rd_addr (rd_ptr_r[PTR_WIDTH-1:0]),
    .rd_data (ram_rd_data_s)
  );

  // Output mapping; in FWFT mode the head word is visible whenever non-empty.
  always_comb begin
    fifo_output    = ram_rd_data_s;
    fifo_full      = full_s;
    fifo_empty     = empty_s;
    fifo_count     = count_s;
    prog_full      = (count_s >= prog_full_thresh);
    prog_empty     = (count_s <= prog_empty_thresh);
    fifo_overflow  = overflow_r;
    fifo_underflow = underflow_r;
    if (FWFT_MODE == FWFT_ON) begin
      fifo_valid = !empty_s;
    end else begin
      fifo_valid = valid_r;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flex
// Drives one standard-mode and one FWFT-mode instance (DEPTH=8, WIDTH=8) with
// identical stimulus and compares both against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flex;

  localparam int D = 8;

  logic       fifo_clk = 1'b0;
  logic       fifo_sync_rst, fifo_flush, fifo_write, fifo_read;
  logic [7:0] fifo_input;
  logic [3:0] pf_thr, pe_thr;

  logic [7:0] s_out, f_out;
  logic       s_valid, f_valid, s_full, f_full, s_empty, f_empty;
  logic       s_pf, f_pf, s_pe, f_pe, s_ovf, f_ovf, s_unf, f_unf;
  logic [3:0] s_cnt, f_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  // reference model state
  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_valid;
  logic [7:0] m_out;

  always #5 fifo_clk = ~fifo_clk;

  sync_fifo_flex #(.FIFO_DEPTH(D), .FIFO_WIDTH(8), .FWFT_MODE(0)) dut_std (
    .fifo_clk(fifo_clk), .fifo_sync_rst(fifo_sync_rst), .fifo_flush(fifo_flush),
    .fifo_write(fifo_write), .fifo_input(fifo_input), .fifo_read(fifo_read),
    .prog_full_thresh(pf_thr), .prog_empty_thresh(pe_thr),
    .fifo_output(s_out), .fifo_valid(s_valid), .fifo_full(s_full), .fifo_empty(s_empty),
    .prog_full(s_pf), .prog_empty(s_pe), .fifo_count(s_cnt),
    .fifo_overflow(s_ovf), .fifo_underflow(s_unf));

  sync_fifo_flex #(.FIFO_DEPTH(D), .FIFO_WIDTH(8), .FWFT_MODE(1)) dut_fwft (
    .fifo_clk(fifo_clk), .fifo_sync_rst(fifo_sync_rst), .fifo_flush(fifo_flush),
    .fifo_write(fifo_write), .fifo_input(fifo_input), .fifo_read(fifo_read),
    .prog_full_thresh(pf_thr), .prog_empty_thresh(pe_thr),
    .fifo_output(f_out), .fifo_valid(f_valid), .fifo_full(f_full), .fifo_empty(f_empty),
    .prog_full(f_pf), .prog_empty(f_pe), .fifo_count(f_cnt),
    .fifo_overflow(f_ovf), .fifo_underflow(f_unf));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = q.size();
    check("std_count", 32'(s_cnt), 32'(sz));
    check("fwft_count", 32'(f_cnt), 32'(sz));
    check("std_full", 32'(s_full), 32'(sz == D));
    check("fwft_full", 32'(f_full), 32'(sz == D));
    check("std_empty", 32'(s_empty), 32'(sz == 0));
    check("fwft_empty", 32'(f_empty), 32'(sz == 0));
    check("std_prog_full", 32'(s_pf), 32'(sz >= int'(pf_thr)));
    check("fwft_prog_full", 32'(f_pf), 32'(sz >= int'(pf_thr)));
    check("std_prog_empty", 32'(s_pe), 32'(sz <= int'(pe_thr)));
    check("fwft_prog_empty", 32'(f_pe), 32'(sz <= int'(pe_thr)));
    check("std_ovf", 32'(s_ovf), 32'(m_ovf));
    check("fwft_ovf", 32'(f_ovf), 32'(m_ovf));
    check("std_unf", 32'(s_unf), 32'(m_unf));
    check("fwft_unf", 32'(f_unf), 32'(m_unf));
    check("std_valid", 32'(s_valid), 32'(m_valid));
    check("std_output", 32'(s_out), 32'(m_out));
    check("fwft_valid", 32'(f_valid), 32'(sz != 0));
    if (sz != 0) check("fwft_output", 32'(f_out), 32'(q[0]));
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit fl, input bit rs);
    bit full, empty;
    fifo_write = w; fifo_input = d; fifo_read = r; fifo_flush = fl; fifo_sync_rst = rs;
    if (rs) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0; m_out = 8'h00;
    end else if (fl) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
    end else begin
      full  = (q.size() == D);
      empty = (q.size() == 0);
      if (w && full)  m_ovf = 1'b1;
      if (r && empty) m_unf = 1'b1;
      m_valid = r && !empty;
      if (r && !empty) m_out = q.pop_front();
      if (w && !full)  q.push_back(d);
    end
    @(posedge fifo_clk);
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    fifo_sync_rst = 1'b0; fifo_flush = 1'b0; fifo_write = 1'b0; fifo_read = 1'b0;
    fifo_input = 8'h00; pf_thr = 4'd6; pe_thr = 4'd2;
    m_out = 8'h00;

    // reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("rst_empty_const", 32'(s_empty), 32'd1);
    check("rst_output_const", 32'(s_out), 32'd0);
    idle();

    // fill 0x01..0x08, thresholds 6/2 exercised along the way
    for (int i = 1; i <= D; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    check("full_const", 32'(s_full), 32'd1);
    check("count8_const", 32'(s_cnt), 32'd8);
    step(1'b1, 8'h09, 1'b0, 1'b0, 1'b0);
    check("ovf_const", 32'(s_ovf), 32'd1);
    check("count_after_ovf", 32'(s_cnt), 32'd8);

    // drain: each word appears one cycle after its read
    for (int i = 1; i <= D; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("drain_word", 32'(s_out), 32'(i));
    end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("unf_const", 32'(s_unf), 32'd1);

    // FWFT: single write is visible with no read
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    check("fwft_aa_valid", 32'(f_valid), 32'd1);
    check("fwft_aa_output", 32'(f_out), 32'hAA);

    // bring to 4 words, then 20 cycles of simultaneous read+write across wrap
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
      check("rw_count4", 32'(s_cnt), 32'd4);
    end

    // flush with read+write at count 5 and both flags set
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < D; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      check("pre_clear_count", 32'(s_cnt), 32'd5);
      check("pre_clear_flags", 32'({s_ovf, s_unf}), 32'd3);
      if (pass == 0) step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0);
      else           step(1'b1, 8'hC3, 1'b1, 1'b0, 1'b1);
      check("clear_count", 32'(s_cnt), 32'd0);
      check("clear_flags", 32'({s_ovf, s_unf}), 32'd0);
      if (pass == 1) check("rst_output_zero", 32'(s_out), 32'd0);
    end

    // randomized traffic with occasional flush/reset and threshold changes
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        pf_thr = 4'($urandom_range(0, 9));
        pe_thr = 4'($urandom_range(0, 9));
      end
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 79) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
